mem_bus_arbiter: RTL and testbench

//  Shares one external single-port memory bus between the IF stage (instruction fetch) and the MEM stage (data load/store).

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_timeout_cnt.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUS_IF = 2'd1,
      ARB_BUS_DM = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_t;

   localparam int STREAK_W = 4;

   // Saturating step so the streak can never wrap past its limit.
   function automatic logic [STREAK_W-1:0] streak_next(
      input logic [STREAK_W-1:0] cur,
      input logic [STREAK_W-1:0] limit
   );
      return (cur == limit) ? cur : cur + 1'b1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Per-transaction watchdog: cleared on grant, counts un-acked bus cycles,
// and flags the cycle whose increment would reach TIMEOUT.
module mem_bus_arbiter_timeout_cnt #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic inc,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   assign expire = inc && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// with DM-first priority, an IF starvation guard, flush discard and timeouts.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int TIMEOUT   = 15,
   parameter int DM_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   input  logic              flush_i,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err,
   output logic              stall_req_o
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DM_STREAK);

   arb_state_t          state;
   logic [STREAK_W-1:0] streak;
   logic                discard;
   logic                in_bus;
   logic                force_if;
   logic                grant_dm;
   logic                grant_if;
   logic                expire;

   assign in_bus   = (state == ARB_BUS_IF) || (state == ARB_BUS_DM);
   assign force_if = if_req && !flush_i && (streak == STREAK_MAX);
   assign grant_dm = (state == ARB_IDLE) && dm_req && !force_if;
   assign grant_if = (state == ARB_IDLE) && !grant_dm && if_req && !flush_i;

   assign stall_req_o = (if_req && !if_ready) || (dm_req && !dm_ready);

   mem_bus_arbiter_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .load   (grant_dm || grant_if),
      .inc    (in_bus && !bus_ack),
      .expire (expire)
   );

   // A fetch flushed while on the bus still runs to ack/timeout; only its
   // completion pulse is dropped. Stores return 0 rather than slave data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARB_IDLE;
         streak    <= '0;
         discard   <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_err   <= 1'b0;
         if_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_ready  <= 1'b0;
         dm_rdata  <= '0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         bus_err  <= 1'b0;
         if (!if_req) begin
            streak <= '0;
         end

         case (state)
            ARB_IDLE: begin
               if (grant_dm) begin
                  state     <= ARB_BUS_DM;
                  bus_req   <= 1'b1;
                  bus_we    <= dm_we;
                  bus_addr  <= dm_addr;
                  bus_wdata <= dm_wdata;
                  if (if_req) begin
                     streak <= streak_next(streak, STREAK_MAX);
                  end
               end else if (grant_if) begin
                  state    <= ARB_BUS_IF;
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_addr <= if_addr;
                  discard  <= 1'b0;
                  streak   <= '0;
               end
            end

            ARB_BUS_IF: begin
               if (flush_i) begin
                  discard <= 1'b1;
               end
               if (bus_ack || expire) begin
                  state   <= ARB_DONE;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  bus_err <= ~bus_ack;
                  if (!discard && !flush_i) begin
                     if_ready <= 1'b1;
                     if_rdata <= bus_ack ? bus_rdata : '0;
                  end
               end
            end

            ARB_BUS_DM: begin
               if (bus_ack || expire) begin
                  state    <= ARB_DONE;
                  bus_req  <= 1'b0;
                  bus_we   <= 1'b0;
                  bus_err  <= ~bus_ack;
                  dm_ready <= 1'b1;
                  dm_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
               end
            end

            ARB_DONE: begin
               state   <= ARB_IDLE;
               discard <= 1'b0;
            end

            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requesters push expected completions,
// a negedge monitor pops and compares whenever a ready pulse appears.
module tb_mem_bus_arbiter;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int TIMEOUT   = 15;
   localparam int DM_STREAK = 4;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req = 1'b0;
   logic              dm_we = 1'b0;
   logic [ADDR_W-1:0] dm_addr = '0;
   logic [DATA_W-1:0] dm_wdata = '0;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic              flush_i = 1'b0;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata = '0;
   logic              bus_ack = 1'b0;
   logic              bus_err;
   logic              stall_req_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Slave behaviour knobs
   int slave_delay = 0;
   bit slave_en = 1'b1;
   int slave_cnt = 0;

   // Monitor bookkeeping
   exp_t        exp_if_q[$];
   exp_t        exp_dm_q[$];
   logic [31:0] grant_log[$];
   logic        we_log[$];
   int          req_run = 0;
   int          last_req_len = 0;
   int          err_pulses = 0;
   logic        prev_bus_req = 1'b0;
   logic [31:0] prev_addr = '0;
   bit          dm_pend = 1'b0;
   bit          if_pend = 1'b0;

   mem_bus_arbiter #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .TIMEOUT   (TIMEOUT),
      .DM_STREAK (DM_STREAK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_ready    (if_ready),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_ready    (dm_ready),
      .flush_i     (flush_i),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .bus_ack     (bus_ack),
      .bus_err     (bus_err),
      .stall_req_o (stall_req_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Slave read data pattern, known to the bench independently of the DUT.
   function automatic logic [31:0] slave_data(input logic [31:0] addr);
      if (addr == 32'h40) return 32'hDEADBEEF;
      return addr ^ 32'hA5A5_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Slave: acks slave_delay cycles after it first sees bus_req (0 = same cycle).
   always @(negedge clk) begin
      bus_ack = 1'b0;
      if (rst || !bus_req) begin
         slave_cnt = 0;
      end else begin
         if (slave_en && slave_cnt == slave_delay) begin
            bus_ack   = 1'b1;
            bus_rdata = slave_data(bus_addr);
         end
         slave_cnt++;
      end
   end

   // Monitor: logs grants, checks bus stability and pops the scoreboard on ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_bus_req = 1'b0;
         req_run = 0;
      end else begin
         if (bus_req) begin
            if (!prev_bus_req) begin
               grant_log.push_back(bus_addr);
               we_log.push_back(bus_we);
            end else begin
               checkOutput("bus_addr_stable", bus_addr, prev_addr);
            end
            req_run++;
         end else if (prev_bus_req) begin
            last_req_len = req_run;
            req_run = 0;
         end
         prev_bus_req = bus_req;
         prev_addr = bus_addr;
         if (bus_err) err_pulses++;

         if (dm_ready) begin
            if (exp_dm_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL dm_unexpected_ready: got dm_ready=1, required no completion");
            end else begin
               e = exp_dm_q.pop_front();
               checkOutput("dm_rdata", dm_rdata, e.data);
               checkOutput("dm_bus_err", 32'(bus_err), 32'(e.err));
            end
         end
         if (if_ready) begin
            if (exp_if_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL if_unexpected_ready: got if_ready=1, required no completion");
            end else begin
               e = exp_if_q.pop_front();
               checkOutput("if_rdata", if_rdata, e.data);
               checkOutput("if_bus_err", 32'(bus_err), 32'(e.err));
            end
         end

         // Requesters may only withdraw after ready (or, for IF, on flush).
         assert (!(dm_pend && !dm_req)) else begin
            errors++;
            $display("[TB] FAIL dm_withdraw: dm_req dropped before dm_ready");
         end
         assert (!(if_pend && !if_req && !flush_i)) else begin
            errors++;
            $display("[TB] FAIL if_withdraw: if_req dropped before if_ready");
         end
      end
      dm_pend = !rst && dm_req && !dm_ready;
      if_pend = !rst && if_req && !if_ready && !flush_i;
   end

   task automatic applyStimulus(input bit is_dm, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      if (is_dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
   endtask

   task automatic wait_ready(input bit is_dm, output int lat);
      logic rdy;
      lat = 0;
      forever begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         rdy = is_dm ? dm_ready : if_ready;
         if (rdy) break;
         checkOutput(is_dm ? "dm_stall" : "if_stall", 32'(stall_req_o), 32'd1);
         if (lat >= 60) begin
            checks++; errors++;
            $display("[TB] FAIL %s_ready_budget: no ready after %0d cycles, required one",
                     is_dm ? "dm" : "if", lat);
            break;
         end
      end
   endtask

   task automatic dm_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err, output int lat);
      exp_t e;
      e.data = exp_data;
      e.err = exp_err;
      @(posedge clk); #1;
      applyStimulus(1'b1, we, addr, wdata);
      exp_dm_q.push_back(e);
      wait_ready(1'b1, lat);
      if (dm_ready && !if_req) checkOutput("dm_stall_release", 32'(stall_req_o), 32'd0);
   endtask

   task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp_data, output int lat);
      exp_t e;
      e.data = exp_data;
      e.err = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, addr, 32'h0);
      exp_if_q.push_back(e);
      wait_ready(1'b0, lat);
   endtask

   task automatic dm_drop();
      @(posedge clk); #1;
      dm_req = 1'b0; dm_we = 1'b0;
   endtask

   task automatic if_drop();
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat, lat_d, lat_i, t_dm, t_if, err_before, seen;
      logic [31:0] exp_g[7];
      logic        exp_w[7];
      logic [31:0] a;
      exp_t e;

      // Reset values
      @(negedge clk);
      checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
      checkOutput("rst_bus_addr", bus_addr, 32'd0);
      checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
      checkOutput("rst_if_ready", 32'(if_ready), 32'd0);
      checkOutput("rst_dm_ready", 32'(dm_ready), 32'd0);
      checkOutput("rst_dm_rdata", dm_rdata, 32'd0);
      checkOutput("rst_stall", 32'(stall_req_o), 32'd0);
      #2 rst = 1'b0;

      // 1: single load, ack in first bus cycle
      grant_log.delete(); we_log.delete();
      dm_txn(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, lat);
      dm_drop();
      checkOutput("t1_latency", 32'(lat), 32'd2);
      checkOutput("t1_grant_addr", grant_log[0], 32'h40);

      // 2: simultaneous IF and DM, DM first
      grant_log.delete(); we_log.delete();
      fork
         begin dm_txn(1'b0, 32'h200, 32'h0, slave_data(32'h200), 1'b0, lat_d); t_dm = cyc; dm_drop(); end
         begin if_txn(32'h300, slave_data(32'h300), lat_i); t_if = cyc; if_drop(); end
      join
      checkOutput("t2_grants", 32'(grant_log.size()), 32'd2);
      checkOutput("t2_first_dm", grant_log[0], 32'h200);
      checkOutput("t2_then_if", grant_log[1], 32'h300);
      checkOutput("t2_if_after_dm", 32'((t_if - t_dm) >= 3), 32'd1);

      // 3: DM streak limit forces one IF grant, store returns 0
      grant_log.delete(); we_log.delete();
      exp_g = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h500, 32'h1010, 32'h1014};
      exp_w = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               a = 32'h1000 + 32'(i * 4);
               if (i == 1) dm_txn(1'b1, a, 32'hCAFE0001, 32'h0, 1'b0, lat_d);
               else        dm_txn(1'b0, a, 32'h0, slave_data(a), 1'b0, lat_d);
            end
            dm_drop();
         end
         begin if_txn(32'h500, slave_data(32'h500), lat_i); if_drop(); end
      join
      checkOutput("t3_grants", 32'(grant_log.size()), 32'd7);
      for (int i = 0; i < 7 && i < grant_log.size(); i++) begin
         checkOutput($sformatf("t3_grant%0d_addr", i), grant_log[i], exp_g[i]);
         checkOutput($sformatf("t3_grant%0d_we", i), 32'(we_log[i]), 32'(exp_w[i]));
      end

      // 4: flush during BUS_IF discards the fetch; flush in IDLE blocks one grant
      grant_log.delete(); we_log.delete();
      slave_delay = 4;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 32'h80, 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      flush_i = 1'b1; if_req = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (if_ready) seen++;
      end
      checkOutput("t4_discard_no_ready", 32'(seen), 32'd0);
      checkOutput("t4_flushed_grant", grant_log[0], 32'h80);
      checkOutput("t4_bus_idle", 32'(bus_req), 32'd0);
      slave_delay = 0;
      @(posedge clk); #1;
      flush_i = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0);
      e.data = slave_data(32'h100); e.err = 1'b0;
      exp_if_q.push_back(e);
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      checkOutput("t4_idle_flush_block", 32'(bus_req), 32'd0);
      wait_ready(1'b0, lat);
      if_drop();
      checkOutput("t4_refetch_latency", 32'(lat), 32'd2);

      // 5: slave never acks -> timeout
      slave_en = 1'b0;
      err_before = err_pulses;
      dm_txn(1'b0, 32'h600, 32'h0, 32'h0, 1'b1, lat);
      dm_drop();
      checkOutput("t5_latency", 32'(lat), 32'd16);
      checkOutput("t5_bus_req_len", 32'(last_req_len), 32'(TIMEOUT));
      checkOutput("t5_err_pulses", 32'(err_pulses - err_before), 32'd1);
      checkOutput("t5_bus_idle", 32'(bus_req), 32'd0);
      slave_en = 1'b1;

      // 6: asynchronous reset mid-transaction, then a fresh access
      slave_delay = 10;
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 32'h680, 32'h0);
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("t6_rst_dm_ready", 32'(dm_ready), 32'd0);
      dm_req = 1'b0;
      @(negedge clk); #3;
      rst = 1'b0;
      slave_delay = 0;
      dm_txn(1'b0, 32'h700, 32'h0, slave_data(32'h700), 1'b0, lat);
      dm_drop();
      checkOutput("t6_fresh_latency", 32'(lat), 32'd2);

      repeat (3) @(posedge clk);
      checkOutput("if_queue_empty", 32'(exp_if_q.size()), 32'd0);
      checkOutput("dm_queue_empty", 32'(exp_dm_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
